// File: rtl/bird_pkg.sv
// Shared definitions for the bird control FSM and its datapath.
package bird_pkg;

    localparam logic [3:0] PREHOLD    = 4'b0100;
    localparam logic [3:0] HOLD       = 4'b0000;
    localparam logic [3:0] CLEAR      = 4'b0001;
    localparam logic [3:0] UP_RIGHT   = 4'b0011;
    localparam logic [3:0] UP_LEFT    = 4'b0010;
    localparam logic [3:0] DOWN_RIGHT = 4'b0110;
    localparam logic [3:0] DOWN_LEFT  = 4'b0111;
    localparam logic [3:0] DRAW       = 4'b0101;
    localparam logic [3:0] SHOT       = 4'b1000;
    localparam logic [3:0] ESCAPE     = 4'b1001;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        FALLING  = 2'd1,
        ESCAPING = 2'd2
    } mode_t;

    function automatic logic is_draw_state(input logic [3:0] s);
        return (s == CLEAR) || (s == DRAW);
    endfunction

endpackage

// File: rtl/sprite_sweeper.sv
// Walks the sprite rectangle row-major, one registered pixel per cycle after start.
module sprite_sweeper #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       enable,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);
    localparam int N    = SPRITE_W * SPRITE_H;
    localparam int CW   = $clog2(N + 1);
    localparam int COLW = $clog2(SPRITE_W + 1);
    localparam int ROWW = $clog2(SPRITE_H + 1);

    logic [CW-1:0]   cnt, cnt_next;
    logic [COLW-1:0] col, cur_col, nxt_col;
    logic [ROWW-1:0] row, cur_row, nxt_row;
    logic            emit;

    assign emit = start || (enable && (cnt < CW'(N)));

    always_comb begin
        cur_col  = start ? '0 : col;
        cur_row  = start ? '0 : row;
        nxt_col  = cur_col + 1'b1;
        nxt_row  = cur_row;
        cnt_next = start ? CW'(1) : cnt + 1'b1;
        if (cur_col == COLW'(SPRITE_W - 1)) begin
            nxt_col = '0;
            nxt_row = cur_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            col    <= '0;
            row    <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
        end else if (emit) begin
            x      <= base_x + 8'(cur_col);
            y      <= base_y + 7'(cur_row);
            colour <= colour_in;
            plot   <= 1'b1;
            col    <= nxt_col;
            row    <= nxt_row;
            cnt    <= cnt_next;
            done   <= (cnt_next == CW'(N));
        end else begin
            // Finished sweep keeps done while the draw state is held.
            plot <= 1'b0;
            if (!enable) done <= 1'b0;
        end
    end

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: position and flight mode, sprite sweep to the plotter, scoring pulses.
module bird_datapath
    import bird_pkg::*;
#(
    parameter int          SPRITE_W    = 8,
    parameter int          SPRITE_H    = 8,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          START_X     = 76,
    parameter int          START_Y     = 100,
    parameter int          STEP        = 1,
    parameter int          FALL_STEP   = 2,
    parameter logic [2:0]  BG_COLOUR   = 3'b011,
    parameter logic [2:0]  BIRD_COLOUR = 3'b000,
    parameter logic [2:0]  SHOT_COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_drawing,
    output logic       flying,
    output logic [7:0] bird_x,
    output logic [6:0] bird_y,
    output logic       hit_pulse,
    output logic       escape_pulse
);
    localparam logic [7:0] X_MAX  = 8'(SCREEN_W - SPRITE_W);
    localparam logic [6:0] Y_MAX  = 7'(SCREEN_H - SPRITE_H);
    localparam logic [7:0] STEP_X = 8'(STEP);
    localparam logic [6:0] STEP_Y = 7'(STEP);
    localparam logic [6:0] FALL   = 7'(FALL_STEP);

    logic [3:0] prev_state;
    mode_t      mode, mode_next;
    logic [7:0] bx_next;
    logic [6:0] by_next;
    logic       hit_next, esc_next;
    logic       in_draw, start, done_r, auto_move;
    logic [2:0] pix_colour;

    assign in_draw      = is_draw_state(state);
    assign start        = in_draw && (state != prev_state);
    // Masked on a state's first cycle so a done left over from CLEAR never leaks into DRAW.
    assign done_drawing = done_r && (state == prev_state);
    assign auto_move    = (state == CLEAR) && done_drawing && (mode != NORMAL);
    assign pix_colour   = (state == CLEAR)  ? BG_COLOUR :
                          (mode == FALLING) ? SHOT_COLOUR : BIRD_COLOUR;

    always_comb begin
        bx_next   = bird_x;
        by_next   = bird_y;
        mode_next = mode;
        hit_next  = 1'b0;
        esc_next  = 1'b0;
        case (state)
            UP_RIGHT, UP_LEFT, DOWN_RIGHT, DOWN_LEFT: begin
                if (mode == NORMAL) begin
                    if (state == UP_RIGHT || state == DOWN_RIGHT)
                        bx_next = (bird_x >= X_MAX - STEP_X) ? X_MAX : bird_x + STEP_X;
                    else
                        bx_next = (bird_x <= STEP_X) ? 8'd0 : bird_x - STEP_X;
                    if (state == UP_RIGHT || state == UP_LEFT)
                        by_next = (bird_y <= STEP_Y) ? 7'd0 : bird_y - STEP_Y;
                    else
                        by_next = (bird_y >= Y_MAX - STEP_Y) ? Y_MAX : bird_y + STEP_Y;
                end
            end
            SHOT:   if (mode == NORMAL) mode_next = FALLING;
            ESCAPE: if (mode == NORMAL) mode_next = ESCAPING;
            CLEAR: begin
                if (auto_move) begin
                    if (mode == FALLING) begin
                        if (bird_y >= Y_MAX - FALL) hit_next = 1'b1;
                        else                        by_next  = bird_y + FALL;
                    end else begin
                        if (bird_y <= FALL) esc_next = 1'b1;
                        else                by_next  = bird_y - FALL;
                    end
                    if (hit_next || esc_next) begin
                        bx_next   = 8'(START_X);
                        by_next   = 7'(START_Y);
                        mode_next = NORMAL;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_state   <= PREHOLD;
            mode         <= NORMAL;
            flying       <= 1'b0;
            bird_x       <= 8'(START_X);
            bird_y       <= 7'(START_Y);
            hit_pulse    <= 1'b0;
            escape_pulse <= 1'b0;
        end else begin
            prev_state   <= state;
            mode         <= mode_next;
            flying       <= (mode_next != NORMAL);
            bird_x       <= bx_next;
            bird_y       <= by_next;
            hit_pulse    <= hit_next;
            escape_pulse <= esc_next;
        end
    end

    sprite_sweeper #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_sweeper (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .enable    (in_draw),
        .base_x    (bird_x),
        .base_y    (bird_y),
        .colour_in (pix_colour),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .done      (done_r)
    );

endmodule
